uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- Receive-side host buffer for the UART; the RX counterpart of the TX register controller.
- Sits between the Rx deserializer (`DataOut`/`Out_rdy`/error flags) and the host.
- Detects each newly completed frame, stores the byte plus its error flags in a small FIFO, and hands entries to the host through a read handshake.
- Tracks overrun and errored-frame statistics.

Parameters:
- DATA_W, 8, frame data width.
- DEPTH, 4, FIFO entries; must be a power of 2.
- ADDR_W, 2, log2(DEPTH).
- DROP_ERR, 0, 1 = frames with parity or stop error are not stored (counted only); 0 = stored with their flags.

Ports:
- clk  input  1  clock; the baud-domain clock shared with Rx.
- rst  input  1  synchronous, active-low reset.
- rx_data  input  DATA_W  byte from Rx (`DataOut`).
- rx_valid  input  1  Rx `Out_rdy`; level, may stay high for several cycles.
- rx_parity_err  input  1  Rx `ParityError`, valid with rx_valid.
- rx_stop_err  input  1  Rx `StopBitError`, valid with rx_valid.
- rd_en  input  1  host read request.
- clr_ovr  input  1  clears the sticky overrun flag.
- data_out  output  DATA_W  byte read out.
- err_out  output  2  {stop_err, parity_err} of the entry read out.
- out_valid  output  1  one-cycle pulse; data_out/err_out updated this cycle.
- rd_underflow  output  1  one-cycle pulse; rd_en seen while empty.
- fifo_empty  output  1  count == 0.
- fifo_full  output  1  count == DEPTH.
- count  output  ADDR_W+1  occupancy, 0..DEPTH.
- overrun  output  1  sticky; a valid frame was lost because the FIFO was full.
- err_cnt  output  8  errored frames received; saturates at 255.

Behaviour:
- **Reset:** all state updates only on posedge clk. rst==0 sampled at a clock edge sets:
  - data_out=0, err_out=0, out_valid=0, rd_underflow=0, count=0, overrun=0, err_cnt=0;
  - wr_ptr=rd_ptr=0;
  - rx_valid_q=1, so a level already high at reset release is not captured;
  - FIFO contents are don't-care.
  - Reset mid-operation discards all entries and any in-flight read.
- **Frame detect:** new_frame = rx_valid & ~rx_valid_q; rx_valid_q <= rx_valid every cycle. Exactly one capture per rising edge of rx_valid, whatever the high duration.
- **Write path** (cycle of new_frame):
  - is_err = rx_parity_err | rx_stop_err.
  - If is_err: err_cnt increments unless already 255.
  - If DROP_ERR==1 and is_err: no write, no overrun effect.
  - Else if a slot is available: mem[wr_ptr] <= {rx_stop_err, rx_parity_err, rx_data}; wr_ptr increments and wraps modulo DEPTH.
  - A slot is available when count<DEPTH, or when count==DEPTH and a valid read occurs in the same cycle.
  - Else: the frame is dropped and overrun <= 1.
- **Read path:**
  - rd_en & ~fifo_empty: data_out/err_out <= mem[rd_ptr]; rd_ptr wraps modulo DEPTH.
  - out_valid is high in the cycle after the rd_en edge, for exactly one cycle; latency is 1 clock. data_out holds its value until the next valid read.
  - rd_en & fifo_empty: no pointer change, data_out held, rd_underflow pulses one cycle later.
  - rd_en held high drains one entry per cycle.
- **Simultaneous events:**
  - Write + read with 0<count<DEPTH: count unchanged.
  - Write + read when empty: the write is accepted, the read is an underflow (no bypass); count becomes 1.
  - Write + read when full: both proceed, count stays DEPTH, overrun is not set.
  - clr_ovr and a new overrun in the same cycle: overrun ends at 1 (set wins).
- **Count and flags:** count = count + wr_accept - rd_accept. fifo_empty and fifo_full are combinational from count.

Test Plan:
1. **Basic store/read.** Reset, then rx_valid edge with rx_data=0x4D and no errors, then pulse rd_en. Required: count 0→1→0; one cycle after rd_en, data_out=0x4D, err_out=00, out_valid=1 for one cycle.
2. **Long level, single capture.** Hold rx_valid high 20 cycles with rx_data=0xB3. Required: exactly one entry (count=1). Also hold rx_valid high through reset release: count stays 0.
3. **Fill, overflow, and order.** Push 0x01..0x05 with no reads (DEPTH=4). Required:
   - fifo_full after the 4th push; 5th push dropped and overrun=1.
   - Draining gives 0x01, 0x02, 0x03, 0x04 in order with wrap-around.
   - clr_ovr returns overrun to 0.
4. **Full with simultaneous read+write.** At count=4, issue rx_valid edge 0xAA in the same cycle as rd_en. Required: overrun stays 0, count=4; a subsequent drain ends with 0xAA.
5. **Error handling.**
   - DROP_ERR=0: frame 0x55 with parity_err, then frame 0x66 with stop_err. Required: err_out=01 then 10; err_cnt=2.
   - DROP_ERR=1, same stimulus: count stays 0, err_cnt=2.
   - 300 errored frames: err_cnt=255.
6. **Underflow and mid-operation reset.** rd_en while empty: rd_underflow pulses, out_valid=0, data_out unchanged. Then with count=3, assert rst=0 for one clock: count=0, fifo_empty=1, and every output is at its reset value.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// Receive-side host buffer: captures each completed Rx frame with its error flags into a
// small FIFO, hands entries to the host on rd_en, and tracks overrun / errored-frame stats.
module uart_rx_buffer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned DROP_ERR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_parity_err,
    input  logic              rx_stop_err,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        err_out,
    output logic              out_valid,
    output logic              rd_underflow,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic [7:0]        err_cnt
);

    localparam int unsigned EntryW = DATA_W + 2;
    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [EntryW-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rx_valid_q;

    logic new_frame;
    logic is_err;
    logic wr_req;
    logic rd_accept;
    logic slot_free;
    logic wr_accept;
    logic ovr_set;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FullCount);

    always_comb begin
        new_frame = rx_valid & ~rx_valid_q;
        is_err    = rx_parity_err | rx_stop_err;
        wr_req    = new_frame & ~((DROP_ERR != 0) & is_err);
        rd_accept = rd_en & ~fifo_empty;
        // A full FIFO still accepts a frame when a read frees a slot in the same cycle.
        slot_free = ~fifo_full | rd_accept;
        wr_accept = wr_req & slot_free;
        ovr_set   = wr_req & ~slot_free;
    end

    always_ff @(posedge clk) begin
        if (rst && wr_accept) begin
            mem[wr_ptr] <= {rx_stop_err, rx_parity_err, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out     <= '0;
            err_out      <= '0;
            out_valid    <= 1'b0;
            rd_underflow <= 1'b0;
            count        <= '0;
            overrun      <= 1'b0;
            err_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            // Treat a level already high at reset release as old, not a new frame.
            rx_valid_q   <= 1'b1;
        end else begin
            rx_valid_q   <= rx_valid;
            out_valid    <= rd_accept;
            rd_underflow <= rd_en & fifo_empty;

            if (rd_accept) begin
                {err_out, data_out} <= mem[rd_ptr];
                rd_ptr              <= rd_ptr + ADDR_W'(1);
            end

            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            count <= count + (ADDR_W + 1)'(wr_accept) - (ADDR_W + 1)'(rd_accept);

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            if (new_frame && is_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized and directed bench for uart_rx_buffer; two instances (DROP_ERR=0 and 1) share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_uart_rx_buffer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_stop_err;
    logic       rd_en;
    logic       clr_ovr;

    logic [7:0] data_out     [2];
    logic [1:0] err_out      [2];
    logic       out_valid    [2];
    logic       rd_underflow [2];
    logic       fifo_empty   [2];
    logic       fifo_full    [2];
    logic [2:0] count        [2];
    logic       overrun      [2];
    logic [7:0] err_cnt      [2];

    uart_rx_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .DROP_ERR(0)) dut_keep (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_stop_err(rx_stop_err), .rd_en(rd_en),
        .clr_ovr(clr_ovr), .data_out(data_out[0]), .err_out(err_out[0]),
        .out_valid(out_valid[0]), .rd_underflow(rd_underflow[0]),
        .fifo_empty(fifo_empty[0]), .fifo_full(fifo_full[0]), .count(count[0]),
        .overrun(overrun[0]), .err_cnt(err_cnt[0])
    );

    uart_rx_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .DROP_ERR(1)) dut_drop (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_stop_err(rx_stop_err), .rd_en(rd_en),
        .clr_ovr(clr_ovr), .data_out(data_out[1]), .err_out(err_out[1]),
        .out_valid(out_valid[1]), .rd_underflow(rd_underflow[1]),
        .fifo_empty(fifo_empty[1]), .fifo_full(fifo_full[1]), .count(count[1]),
        .overrun(overrun[1]), .err_cnt(err_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each stored entry is {stop, parity, data}.
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    bit         m_prev [2];
    bit         m_ovr  [2];
    int         m_errc [2];
    logic [7:0] m_data [2];
    logic [1:0] m_err  [2];
    bit         m_ov   [2];
    bit         m_uf   [2];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qclear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    task automatic qpush(input int k, input logic [9:0] v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qpop(input int k, output logic [9:0] v);
        if (k == 0) v = q0.pop_front(); else v = q1.pop_front();
    endtask

    task automatic model_step(input int k, input bit drop);
        bit         nf;
        bit         is_err;
        bit         rd_ok;
        bit         avail;
        logic [9:0] e;
        if (!rst) begin
            qclear(k);
            m_prev[k] = 1'b1;
            m_ovr[k]  = 1'b0;
            m_errc[k] = 0;
            m_data[k] = '0;
            m_err[k]  = '0;
            m_ov[k]   = 1'b0;
            m_uf[k]   = 1'b0;
            return;
        end
        nf        = rx_valid && !m_prev[k];
        m_prev[k] = rx_valid;
        is_err    = rx_parity_err || rx_stop_err;
        rd_ok     = rd_en && (qsize(k) != 0);
        avail     = (qsize(k) < DEPTH) || rd_ok;
        m_ov[k]   = rd_ok;
        m_uf[k]   = rd_en && (qsize(k) == 0);
        if (rd_ok) begin
            qpop(k, e);
            m_data[k] = e[7:0];
            m_err[k]  = e[9:8];
        end
        if (clr_ovr) m_ovr[k] = 1'b0;
        if (nf) begin
            if (is_err && m_errc[k] < 255) m_errc[k]++;
            if (!(drop && is_err)) begin
                if (avail) qpush(k, {rx_stop_err, rx_parity_err, rx_data});
                else m_ovr[k] = 1'b1;
            end
        end
    endtask

    task automatic compare(input int k);
        string s;
        s = (k == 0) ? "keep" : "drop";
        check_eq({s, ".data_out"},     32'(data_out[k]),     32'(m_data[k]));
        check_eq({s, ".err_out"},      32'(err_out[k]),      32'(m_err[k]));
        check_eq({s, ".out_valid"},    32'(out_valid[k]),    32'(m_ov[k]));
        check_eq({s, ".rd_underflow"}, 32'(rd_underflow[k]), 32'(m_uf[k]));
        check_eq({s, ".count"},        32'(count[k]),        32'(qsize(k)));
        check_eq({s, ".fifo_empty"},   32'(fifo_empty[k]),   32'(qsize(k) == 0));
        check_eq({s, ".fifo_full"},    32'(fifo_full[k]),    32'(qsize(k) == DEPTH));
        check_eq({s, ".overrun"},      32'(overrun[k]),      32'(m_ovr[k]));
        check_eq({s, ".err_cnt"},      32'(err_cnt[k]),      32'(m_errc[k]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        compare(0);
        compare(1);
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit pe, input bit se,
                       input bit rd, input bit clr, input bit rn);
        rx_valid      = v;
        rx_data       = d;
        rx_parity_err = pe;
        rx_stop_err   = se;
        rd_en         = rd;
        clr_ovr       = clr;
        rst           = rn;
        step();
    endtask

    task automatic push(input logic [7:0] d, input bit pe, input bit se);
        cyc(1'b1, d, pe, se, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rx_valid = 1'b0; rx_data = '0; rx_parity_err = 1'b0; rx_stop_err = 1'b0;
        rd_en = 1'b0; clr_ovr = 1'b0; rst = 1'b0;

        // Basic store/read
        do_reset();
        check_eq("t1_reset_count", 32'(count[0]), 32'd0);
        push(8'h4D, 1'b0, 1'b0);
        check_eq("t1_count_one", 32'(count[0]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t1_data", 32'(data_out[0]), 32'h4D);
        check_eq("t1_valid", 32'(out_valid[0]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t1_valid_pulse", 32'(out_valid[0]), 32'd0);

        // Long level captures once; level held through reset release captures nothing
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t2_single", 32'(count[0]), 32'd1);
        cyc(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t2_held_reset", 32'(count[0]), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Fill, overflow, drain order, clear overrun
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), 1'b0, 1'b0);
            if (i == 4) check_eq("t3_full", 32'(fifo_full[0]), 32'd1);
        end
        check_eq("t3_overrun", 32'(overrun[0]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check_eq("t3_order", 32'(data_out[0]), 32'(i));
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("t3_clr_ovr", 32'(overrun[0]), 32'd0);

        // Full with simultaneous read and write
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t4_count", 32'(count[0]), 32'd4);
        check_eq("t4_no_ovr", 32'(overrun[0]), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t4_last", 32'(data_out[0]), 32'hAA);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Error handling on both instances
        do_reset();
        push(8'h55, 1'b1, 1'b0);
        push(8'h66, 1'b0, 1'b1);
        check_eq("t5_drop_count", 32'(count[1]), 32'd0);
        check_eq("t5_errcnt", 32'(err_cnt[1]), 32'd2);
        pop();
        check_eq("t5_err_par", 32'(err_out[0]), 32'd1);
        pop();
        check_eq("t5_err_stop", 32'(err_out[0]), 32'd2);
        for (int i = 0; i < 300; i++) push(8'(i), 1'b1, 1'(i % 2));
        check_eq("t5_sat", 32'(err_cnt[0]), 32'd255);

        // Underflow, then mid-operation reset
        do_reset();
        push(8'h3C, 1'b0, 1'b0);
        pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t6_underflow", 32'(rd_underflow[0]), 32'd1);
        check_eq("t6_data_held", 32'(data_out[0]), 32'h3C);
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t6_rst_count", 32'(count[0]), 32'd0);
        check_eq("t6_rst_empty", 32'(fifo_empty[0]), 32'd1);
        check_eq("t6_rst_data", 32'(data_out[0]), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'(($urandom % 3) == 0), 8'($urandom), 1'(($urandom % 6) == 0),
                1'(($urandom % 8) == 0), 1'(($urandom % 3) == 0),
                1'(($urandom % 10) == 0), 1'(($urandom % 150) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
